hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the RISCV16 5-stage core; it sits beside the forwarding unit.
- Handles the hazards forwarding cannot resolve:
  - load-use stall (one bubble),
  - taken-branch flush,
  - data-memory wait-state freeze, including a pending-branch capture register, a timeout error flag and a saturating stall performance counter.
- Drives PC and pipeline-register write enables, flushes and bubbles.

---
 rtl/core_pkg.sv | 25 ++
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry, hazard FSM states, bubble/NOP encodings.
// No logic; constants and types only.
// Used by the hazard controller, pipeline registers and the forwarding unit.
package core_pkg;

  // Architectural register file: 16 registers, x0 hard-wired to zero
  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // Hazard controller sequencing states
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEMWAIT  = 2'd1,
    HZ_BRREPLAY = 2'd2
  } hazard_state_e;

  // Encoding loaded into IF/ID on a flush (canonical NOP: addi x0,x0,0)
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Control bits a bubble forces in ID/EX and MEM/WB
  localparam logic BUBBLE_REGWRITE = 1'b0;
  localparam logic BUBBLE_MEMREAD  = 1'b0;
  localparam logic BUBBLE_MEMWRITE = 1'b0;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use bubble, taken-branch flush, data-memory wait freeze.
// Latency: outputs combinational from registered state and current inputs.
// Backpressure: dmem wait freezes PC/IF/ID/EX; a branch seen while frozen is replayed once.
module hazard_ctrl #(
  parameter int                 REG_W       = core_pkg::REG_W,
  parameter int                 TMO_W       = 8,
  parameter logic [TMO_W-1:0]   MEM_TIMEOUT = 8'd200,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_W-1:0]  IFID_RS1,
  input  logic [REG_W-1:0]  IFID_RS2,
  input  logic              IFID_usesRS2,
  input  logic [REG_W-1:0]  IDEX_RD,
  input  logic              IDEX_memRead,
  input  logic              EX_branchTaken,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              pc_selBranch,
  output logic              IFID_write,
  output logic              IFID_flush,
  output logic              IDEX_write,
  output logic              IDEX_flush,
  output logic              EXMEM_write,
  output logic              MEMWB_bubble,
  output logic              mem_error,
  output logic [CNT_W-1:0]  stall_count
);
  import core_pkg::*;

  hazard_state_e      r_state;
  hazard_state_e      w_state_nxt;
  logic               r_br_pend;
  logic               w_br_pend_nxt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_mem_error;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_luse;
  logic               w_mwait;
  logic               w_tmo_hit;

  // A load in EX writing a register the ID instruction reads; x0 never creates a dependency
  assign w_luse = IDEX_memRead && (IDEX_RD != '0) &&
                  ((IDEX_RD == IFID_RS1) || (IFID_usesRS2 && (IDEX_RD == IFID_RS2)));

  assign w_mwait = dmem_req && !dmem_ready;

  // Wait limit reached while memory still has not answered
  assign w_tmo_hit = (r_state == HZ_MEMWAIT) && !dmem_ready &&
                     (r_tmo_cnt >= (MEM_TIMEOUT - 1'b1));

  // Output decode and next-state selection; priority is mem wait > branch > load-use
  always_comb begin
    pc_write      = 1'b1;
    pc_selBranch  = 1'b0;
    IFID_write    = 1'b1;
    IFID_flush    = 1'b0;
    IDEX_write    = 1'b1;
    IDEX_flush    = 1'b0;
    EXMEM_write   = 1'b1;
    MEMWB_bubble  = 1'b0;
    w_state_nxt   = r_state;
    w_br_pend_nxt = r_br_pend;

    case (r_state)
      HZ_RUN: begin
        if (w_mwait) begin
          pc_write      = 1'b0;
          IFID_write    = 1'b0;
          IDEX_write    = 1'b0;
          EXMEM_write   = 1'b0;
          MEMWB_bubble  = 1'b1;
          // A branch resolving now would be lost under the freeze; remember it
          w_br_pend_nxt = EX_branchTaken;
          w_state_nxt   = HZ_MEMWAIT;
        end else if (EX_branchTaken) begin
          pc_selBranch  = 1'b1;
          IFID_flush    = 1'b1;
          IDEX_flush    = 1'b1;
        end else if (w_luse) begin
          // One bubble suffices: next cycle the load has left EX
          pc_write      = 1'b0;
          IFID_write    = 1'b0;
          IDEX_flush    = 1'b1;
        end
      end

      HZ_MEMWAIT: begin
        pc_write      = 1'b0;
        IFID_write    = 1'b0;
        IDEX_write    = 1'b0;
        w_br_pend_nxt = r_br_pend || EX_branchTaken;
        if (dmem_ready) begin
          // Access completes: let the MEM result advance, front of pipe stays held
          EXMEM_write  = 1'b1;
          MEMWB_bubble = 1'b0;
          w_state_nxt  = w_br_pend_nxt ? HZ_BRREPLAY : HZ_RUN;
        end else begin
          EXMEM_write  = 1'b0;
          MEMWB_bubble = 1'b1;
        end
      end

      HZ_BRREPLAY: begin
        // Held branch in EX still presents its target; redirect now
        pc_selBranch  = 1'b1;
        IFID_flush    = 1'b1;
        IDEX_flush    = 1'b1;
        w_br_pend_nxt = 1'b0;
        w_state_nxt   = HZ_RUN;
      end

      default: begin
        w_br_pend_nxt = 1'b0;
        w_state_nxt   = HZ_RUN;
      end
    endcase
  end

  // FSM state and pending-branch capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HZ_RUN;
      r_br_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_br_pend <= w_br_pend_nxt;
    end
  end

  // Wait-cycle counter: counts only while stalled on memory, saturates so it cannot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == HZ_MEMWAIT) && !dmem_ready) begin
      if (r_tmo_cnt != '1) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // Sticky timeout flag; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_error <= 1'b0;
    end else if (w_tmo_hit) begin
      r_mem_error <= 1'b1;
    end
  end

  // Saturating count of cycles where the PC did not advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!pc_write && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign mem_error   = r_mem_error;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus multi-cycle sequences.
// Expected outputs are queued when inputs are driven and compared mid-cycle.
// Stall counter expectation comes from a small saturating model.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       IFID_RS1, IFID_RS2, IDEX_RD;
  logic             IFID_usesRS2, IDEX_memRead, EX_branchTaken, dmem_req, dmem_ready;
  logic             pc_write, pc_selBranch, IFID_write, IFID_flush;
  logic             IDEX_write, IDEX_flush, EXMEM_write, MEMWB_bubble, mem_error;
  logic [CNT_W-1:0] stall_count;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_RS1(IFID_RS1), .IFID_RS2(IFID_RS2), .IFID_usesRS2(IFID_usesRS2),
    .IDEX_RD(IDEX_RD), .IDEX_memRead(IDEX_memRead), .EX_branchTaken(EX_branchTaken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_selBranch(pc_selBranch), .IFID_write(IFID_write),
    .IFID_flush(IFID_flush), .IDEX_write(IDEX_write), .IDEX_flush(IDEX_flush),
    .EXMEM_write(EXMEM_write), .MEMWB_bubble(MEMWB_bubble),
    .mem_error(mem_error), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: pc_write, pc_selBranch, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_write, MEMWB_bubble
  localparam logic [7:0] F_RUN = 8'hAA;  // all enables, no flush
  localparam logic [7:0] F_LU  = 8'h0E;  // load-use bubble
  localparam logic [7:0] F_BR  = 8'hFE;  // branch redirect + flushes
  localparam logic [7:0] F_FRZ = 8'h01;  // full freeze, MEM/WB bubble
  localparam logic [7:0] F_RDY = 8'h02;  // memory completes, front held

  typedef struct packed {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       uses2;
    logic [3:0] rd;
    logic       memrd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [7:0] flags;
    logic       merr;
  } vec_t;

  typedef struct packed {
    logic [7:0]       flags;
    logic             merr;
    logic [CNT_W-1:0] stall;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  vec_t       tbl[18];

  function automatic vec_t v(input logic [3:0] rs1, input logic [3:0] rs2, input logic uses2,
                             input logic [3:0] rd, input logic memrd, input logic br,
                             input logic req, input logic rdy, input logic [7:0] fl,
                             input logic me);
    vec_t t;
    t.rs1 = rs1; t.rs2 = rs2; t.uses2 = uses2; t.rd = rd; t.memrd = memrd;
    t.br = br; t.req = req; t.rdy = rdy; t.flags = fl; t.merr = me;
    return t;
  endfunction

  // Pop the oldest expectation and compare against the live outputs
  task automatic compare(input string name);
    exp_t e;
    logic [7:0] act;
    act = {pc_write, pc_selBranch, IFID_write, IFID_flush,
           IDEX_write, IDEX_flush, EXMEM_write, MEMWB_bubble};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    if (act !== e.flags || mem_error !== e.merr || stall_count !== e.stall) begin
      n_errors++;
      $display("FAIL %s: got flags=%h mem_error=%b stall=%0d, want flags=%h mem_error=%b stall=%0d",
               name, act, mem_error, stall_count, e.flags, e.merr, e.stall);
    end
    if (!e.flags[7] && rst_n) begin
      if (exp_stall != '1) exp_stall = exp_stall + 1'b1;
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), check at the following negedge
  task automatic step(input string name, input vec_t t);
    exp_t e;
    IFID_RS1 = t.rs1; IFID_RS2 = t.rs2; IFID_usesRS2 = t.uses2;
    IDEX_RD = t.rd; IDEX_memRead = t.memrd; EX_branchTaken = t.br;
    dmem_req = t.req; dmem_ready = t.rdy;
    e.flags = t.flags; e.merr = t.merr; e.stall = exp_stall;
    exp_q.push_back(e);
    @(negedge clk);
    compare(name);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    IFID_RS1 = '0; IFID_RS2 = '0; IFID_usesRS2 = 1'b0; IDEX_RD = '0;
    IDEX_memRead = 1'b0; EX_branchTaken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Assert reset, check reset outputs without any clock edge, then release cleanly
  task automatic do_reset(input string name);
    exp_t e;
    set_idle();
    rst_n = 1'b0;
    #1;
    exp_stall = '0;
    e.flags = F_RUN; e.merr = 1'b0; e.stall = '0;
    exp_q.push_back(e);
    compare(name);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b1;
    set_idle();
    #2;

    tbl[0]  = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_RUN, 1'b0); // idle
    tbl[1]  = v(4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, F_LU,  1'b0); // load-use on RS1
    tbl[2]  = v(4'd3, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, F_RUN, 1'b0); // no re-detect, stall=1
    tbl[3]  = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, F_RUN, 1'b0); // x0 destination
    tbl[4]  = v(4'd1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, F_RUN, 1'b0); // RS2 not used
    tbl[5]  = v(4'd1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, F_LU,  1'b0); // RS2 used -> stall
    tbl[6]  = v(4'd7, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, F_BR,  1'b0); // branch beats load-use
    tbl[7]  = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, F_BR,  1'b0); // plain branch
    tbl[8]  = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_RUN, 1'b0);
    tbl[9]  = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_FRZ, 1'b0); // wait + branch
    tbl[10] = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, F_FRZ, 1'b0);
    tbl[11] = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, F_FRZ, 1'b0);
    tbl[12] = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, F_RDY, 1'b0); // ready
    tbl[13] = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_BR,  1'b0); // replay
    tbl[14] = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_RUN, 1'b0);
    tbl[15] = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, F_FRZ, 1'b0); // wait, no branch
    tbl[16] = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, F_RDY, 1'b0);
    tbl[17] = v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_RUN, 1'b0); // no replay

    do_reset("reset_init");
    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Timeout: first frozen cycle is in RUN, flag visible after 200 MEMWAIT cycles
    do_reset("reset_tmo");
    for (int n = 1; n <= 205; n++) begin
      step($sformatf("tmo%0d", n),
           v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, F_FRZ, (n >= 202)));
    end
    step("tmo_ready", v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, F_RDY, 1'b1));
    step("tmo_sticky", v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_RUN, 1'b1));
    for (int n = 0; n < 3; n++) begin
      step($sformatf("rewait%0d", n),
           v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, F_FRZ, 1'b1));
    end

    // Asynchronous reset in the middle of a MEMWAIT cycle with a branch pending
    set_idle();
    rst_n = 1'b0;
    #1;
    exp_stall = '0;
    e.flags = F_RUN; e.merr = 1'b0; e.stall = '0;
    exp_q.push_back(e);
    compare("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Would freeze or replay if state/br_pend survived reset
    step("post_rst", v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_RUN, 1'b0));

    // Saturation: 2^CNT_W+5 stalled cycles leave the counter at all-ones
    for (int n = 0; n < (1 << CNT_W) + 5; n++) begin
      step($sformatf("sat%0d", n),
           v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, F_FRZ, 1'b0));
    end
    step("sat_ready", v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, F_RDY, 1'b0));
    step("sat_final", v(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, F_RUN, 1'b0));
    n_checks++;
    if (stall_count !== 4'd15) begin
      n_errors++;
      $display("FAIL sat_value: got stall=%0d, want 15", stall_count);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
